// File: rtl/mem_requester_pkg.sv
// Shared widths, memory count/code values and defaults for the memory requester.
package mem_requester_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int MEM_CODE_W  = 3;

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    function automatic logic code_is_error(input logic [MEM_CODE_W-1:0] code);
        return (code == MEM_CODE_MISALIGNED) || (code == MEM_CODE_OUT_OF_BOUNDS);
    endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Pipeline-side handshake plus peripheral request/response bus of the memory requester.
interface mem_requester_if;
    import mem_requester_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
    logic                   load_unsigned;

    logic [ADDR_W-1:0]      req_addr;
    logic [WORD_W-1:0]      req_wr_data;
    logic                   req_wr_en;
    logic [MEM_COUNT_W-1:0] req_count;
    logic [WORD_W-1:0]      res_rd_data;
    logic [MEM_CODE_W-1:0]  res_code;

    logic                   done;
    logic [WORD_W-1:0]      rd_data;
    logic [MEM_CODE_W-1:0]  code;
    logic                   err;
    logic                   timeout;

    // master is the requester itself; slave is the pipeline/peripheral environment.
    modport master (
        input  valid, addr, wr_data, wr_en, count, load_unsigned, res_rd_data, res_code,
        output ready, req_addr, req_wr_data, req_wr_en, req_count,
        output done, rd_data, code, err, timeout
    );

    modport slave (
        output valid, addr, wr_data, wr_en, count, load_unsigned, res_rd_data, res_code,
        input  ready, req_addr, req_wr_data, req_wr_en, req_count,
        input  done, rd_data, code, err, timeout
    );

endinterface

// File: rtl/mem_requester_load_extend.sv
// Sign- or zero-extends right-aligned load data according to the access size.
module mem_load_extend
    import mem_requester_pkg::*;
(
    input  logic [WORD_W-1:0]      data,
    input  logic [MEM_COUNT_W-1:0] count,
    input  logic                   is_unsigned,
    output logic [WORD_W-1:0]      result
);

    always_comb begin
        result = data;
        case (count)
            MEM_COUNT_BYTE: result = {{(WORD_W-8){~is_unsigned & data[7]}}, data[7:0]};
            MEM_COUNT_HALF: result = {{(WORD_W-16){~is_unsigned & data[15]}}, data[15:0]};
            default:        result = data;
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// Memory requester: accepts one load/store, issues a one-cycle peripheral request,
// waits (bounded by a timeout) for the response and returns a one-cycle completion.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
    localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            areset,
    mem_requester_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_n;
    logic [TIMEOUT_W-1:0]   cnt, cnt_n;
    logic [MEM_COUNT_W-1:0] lat_count, lat_count_n;
    logic                   lat_unsigned, lat_unsigned_n;

    logic [ADDR_W-1:0]      req_addr_q, req_addr_n;
    logic [WORD_W-1:0]      req_wr_data_q, req_wr_data_n;
    logic                   req_wr_en_q, req_wr_en_n;
    logic [MEM_COUNT_W-1:0] req_count_q, req_count_n;

    logic                   done_q, done_n;
    logic [WORD_W-1:0]      rd_data_q, rd_data_n;
    logic [MEM_CODE_W-1:0]  code_q, code_n;
    logic                   err_q, err_n;
    logic                   timeout_q, timeout_n;
    logic [WORD_W-1:0]      ext_data;

    mem_load_extend u_extend (
        .data        (bus.res_rd_data),
        .count       (lat_count),
        .is_unsigned (lat_unsigned),
        .result      (ext_data)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lat_count     <= MEM_COUNT_NONE;
            lat_unsigned  <= 1'b0;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
            req_wr_en_q   <= 1'b0;
            req_count_q   <= MEM_COUNT_NONE;
            done_q        <= 1'b0;
            rd_data_q     <= '0;
            code_q        <= MEM_CODE_INVALID;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            lat_count     <= lat_count_n;
            lat_unsigned  <= lat_unsigned_n;
            req_addr_q    <= req_addr_n;
            req_wr_data_q <= req_wr_data_n;
            req_wr_en_q   <= req_wr_en_n;
            req_count_q   <= req_count_n;
            done_q        <= done_n;
            rd_data_q     <= rd_data_n;
            code_q        <= code_n;
            err_q         <= err_n;
            timeout_q     <= timeout_n;
        end
    end

    // Request registers are loaded on acceptance so they are visible for exactly the REQ cycle.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        lat_count_n    = lat_count;
        lat_unsigned_n = lat_unsigned;
        req_addr_n     = '0;
        req_wr_data_n  = '0;
        req_wr_en_n    = 1'b0;
        req_count_n    = MEM_COUNT_NONE;
        done_n         = 1'b0;
        rd_data_n      = rd_data_q;
        code_n         = code_q;
        err_n          = err_q;
        timeout_n      = timeout_q;

        case (state)
            ST_IDLE: begin
                if (bus.valid) begin
                    if (bus.count != MEM_COUNT_NONE) begin
                        lat_count_n    = bus.count;
                        lat_unsigned_n = bus.load_unsigned;
                        req_addr_n     = bus.addr;
                        req_wr_data_n  = bus.wr_data;
                        req_wr_en_n    = bus.wr_en;
                        req_count_n    = bus.count;
                        state_n        = ST_REQ;
                    end else begin
                        done_n    = 1'b1;
                        rd_data_n = '0;
                        code_n    = MEM_CODE_INVALID;
                        err_n     = 1'b0;
                        timeout_n = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                cnt_n   = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.res_code != MEM_CODE_INVALID) begin
                    done_n    = 1'b1;
                    code_n    = bus.res_code;
                    err_n     = code_is_error(bus.res_code);
                    rd_data_n = (bus.res_code == MEM_CODE_READ) ? ext_data : '0;
                    timeout_n = 1'b0;
                    state_n   = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    done_n    = 1'b1;
                    code_n    = MEM_CODE_INVALID;
                    err_n     = 1'b1;
                    rd_data_n = '0;
                    timeout_n = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    cnt_n = cnt + TIMEOUT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.ready       = (state == ST_IDLE);
    assign bus.req_addr    = req_addr_q;
    assign bus.req_wr_data = req_wr_data_q;
    assign bus.req_wr_en   = req_wr_en_q;
    assign bus.req_count   = req_count_q;
    assign bus.done        = done_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.code        = code_q;
    assign bus.err         = err_q;
    assign bus.timeout     = timeout_q;

endmodule
